seg7_scan_driver: RTL

Parametrised time-multiplexed driver for a common-anode multi-digit seven-segment display.
- Scans N_DIGITS hex digits with an inter-digit blanking gap to suppress ghosting; supports per-digit blank and decimal point.
- Inputs are captured into shadow registers once per frame, so a display never tears mid-scan.
- Sits between the channel/status logic and the board segment/anode pins. Generalises the earlier single-digit channel indicator.

---
 rtl/seg7_pkg.sv | 18 +
 rtl/seg7_scan_driver_if.sv | 44 ++++
 rtl/seg7_hex_decode.sv | 12 +
 rtl/seg7_scan_driver.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Optional feature macro: SEG7_DIMMING_EN (PWM brightness control).
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    // All segments dark (active-low).
    localparam seg7_t SEG7_OFF = 7'h7F;

    // Hex digit to active-low segment pattern, a=[0] .. g=[6].
    localparam seg7_t SEG7_HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Digit/status inputs and board-pin outputs of the scan driver.
// With SEG7_DIMMING_EN defined the brightness signal is added.
interface seg7_scan_driver_if #(
    parameter int unsigned N_DIGITS = 4
`ifdef SEG7_DIMMING_EN
    ,
    parameter int unsigned PWM_BITS = 4
`endif
);

    logic [4*N_DIGITS-1:0] digit_val;
    logic [N_DIGITS-1:0]   dp_in;
    logic [N_DIGITS-1:0]   blank;
`ifdef SEG7_DIMMING_EN
    logic [PWM_BITS-1:0]   brightness;
`endif
    seg7_pkg::seg7_t       seg;
    logic                  dp;
    logic [N_DIGITS-1:0]   an;
    logic                  frame_start;

`ifdef SEG7_DIMMING_EN
    modport master (
        output digit_val, dp_in, blank, brightness,
        input  seg, dp, an, frame_start
    );

    modport slave (
        input  digit_val, dp_in, blank, brightness,
        output seg, dp, an, frame_start
    );
`else
    modport master (
        output digit_val, dp_in, blank,
        input  seg, dp, an, frame_start
    );

    modport slave (
        input  digit_val, dp_in, blank,
        output seg, dp, an, frame_start
    );
`endif

endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex digit to active-low seven-segment decoder.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] val,
    output seg7_t      seg_c
);

    // Straight table lookup.
    assign seg_c = SEG7_HEX[val];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment scan driver.
// Inputs are shadowed once per frame; each digit slot starts with a
// blanking gap. Optional feature macro: SEG7_DIMMING_EN adds PWM
// brightness gating of the active window.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned N_DIGITS     = 4,
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000,
    parameter int unsigned PWM_BITS     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg7_scan_driver_if.slave     bus
);

    localparam int unsigned PCNT_W = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned VAL_W  = 4 * N_DIGITS;

    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(REFRESH_DIV - 1);
    localparam logic [PCNT_W-1:0] BLANK_END = PCNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DIGITS - 1);

    // Reject configurations outside the supported range at elaboration.
    if (N_DIGITS < 1 || N_DIGITS > 8 || REFRESH_DIV < 4 ||
        BLANK_CYCLES < 1 || BLANK_CYCLES >= REFRESH_DIV || PWM_BITS < 1) begin : g_bad_cfg
        $error("seg7_scan_driver: illegal parameter combination");
    end

    logic [PCNT_W-1:0]   pcnt;
    logic [IDX_W-1:0]    idx;
    logic                init;
    logic [VAL_W-1:0]    sh_val;
    logic [N_DIGITS-1:0] sh_dp;
    logic [N_DIGITS-1:0] sh_blank;
`ifdef SEG7_DIMMING_EN
    logic [PWM_BITS-1:0] sh_bright;
    logic [PWM_BITS-1:0] pwm_cnt;
`endif

    logic                slot_end_c;
    logic                load_c;
    logic [3:0]          digit_c;
    logic                dp_sel_c;
    logic                blank_sel_c;
    logic                gate_c;
    logic                active_c;
    logic [N_DIGITS-1:0] an_on_c;
    seg7_t               hex_c;

    assign slot_end_c = (pcnt == PCNT_LAST);
    assign load_c     = init | (slot_end_c & (idx == IDX_LAST));
    assign an_on_c    = ~(N_DIGITS'(1) << idx);

    // Select the shadowed fields of the digit currently being scanned.
    always_comb begin
        digit_c     = 4'h0;
        dp_sel_c    = 1'b0;
        blank_sel_c = 1'b0;
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            if (idx == IDX_W'(i)) begin
                digit_c     = sh_val[4*i +: 4];
                dp_sel_c    = sh_dp[i];
                blank_sel_c = sh_blank[i];
            end
        end
    end

`ifdef SEG7_DIMMING_EN
    assign gate_c = (pwm_cnt < sh_bright);
`else
    assign gate_c = 1'b1;
`endif

    assign active_c = (pcnt >= BLANK_END) & ~blank_sel_c & gate_c;

    seg7_hex_decode u_hex (
        .val   (digit_c),
        .seg_c (hex_c)
    );

    // Slot counter and digit index; init marks the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
            idx  <= '0;
            init <= 1'b1;
        end else begin
            init <= 1'b0;
            if (slot_end_c) begin
                pcnt <= '0;
                idx  <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end else begin
                pcnt <= pcnt + PCNT_W'(1);
            end
        end
    end

    // Shadow registers, reloaded only at frame boundaries so a scan never tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_val    <= '0;
            sh_dp     <= '0;
            sh_blank  <= '0;
`ifdef SEG7_DIMMING_EN
            sh_bright <= '0;
`endif
        end else if (load_c) begin
            sh_val    <= bus.digit_val;
            sh_dp     <= bus.dp_in;
            sh_blank  <= bus.blank;
`ifdef SEG7_DIMMING_EN
            sh_bright <= bus.brightness;
`endif
        end
    end

`ifdef SEG7_DIMMING_EN
    // Free-running PWM phase counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end
`endif

    // Registered pin outputs: dark unless inside a lit active window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.seg         <= SEG7_OFF;
            bus.dp          <= 1'b1;
            bus.an          <= '1;
            bus.frame_start <= 1'b0;
        end else begin
            bus.seg         <= active_c ? hex_c : SEG7_OFF;
            bus.dp          <= active_c ? ~dp_sel_c : 1'b1;
            bus.an          <= active_c ? an_on_c : '1;
            bus.frame_start <= load_c;
        end
    end

endmodule
